seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for the board's 8-digit common-anode seven-segment display.
- Latches a 32-bit hex value and cycles through the digits, producing the 3-bit digit index, the active-low digit select and the active-low segment pattern.
- Generates the digit index that the display's 3-to-8 select decode consumes, and also outputs the decoded select directly.
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seg7_scan_driver.sv | 100 ++++++++++
 tb/tb_seg7_scan_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment scan driver with an inter-digit blanking gap.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module seg7_scan_driver #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_mask,
    output logic [2:0]  num,
    output logic [7:0]  sel,
    output logic [7:0]  seg
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST_BLANK = PW'(BLANK_CYC - 1);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(CLK_DIV - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [2:0]    num_n;
    logic [31:0]   data_reg, data_cur;
    logic [3:0]    nib;
    logic [7:0]    seg_n;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        pre_n   = pre + PW'(1);
        num_n   = num;
        if (!en) begin
            state_n = BLANK;
            pre_n   = '0;
            num_n   = '0;
        end else if (state == BLANK) begin
            if (pre == LAST_BLANK) state_n = SHOW;
        end else if (pre == LAST_SLOT) begin
            state_n = BLANK;
            pre_n   = '0;
            num_n   = num + 3'd1;
        end
    end

    // Forward a same-cycle load so the new value is visible one cycle after the strobe.
    always_comb begin
        data_cur = load ? data_in : data_reg;
        nib      = data_cur[{num_n, 2'b00} +: 4];
        seg_n    = {~dp_mask[num_n], decode(nib)};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (num_n != 3'd0 && (data_cur >> {num_n, 2'b00}) == 32'd0) seg_n[6:0] = 7'h7F;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            state    <= BLANK;
            pre      <= '0;
            num      <= '0;
            sel      <= 8'hFF;
            seg      <= 8'hFF;
        end else begin
            if (load) data_reg <= data_in;
            state <= state_n;
            pre   <= pre_n;
            num   <= num_n;
            if (state_n == SHOW) begin
                sel <= ~(8'h01 << num_n);
                seg <= seg_n;
            end else begin
                sel <= 8'hFF;
                seg <= 8'hFF;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Table-driven bench for seg7_scan_driver with a queue scoreboard; CLK_DIV=4, BLANK_CYC=1.
module tb_seg7_scan_driver;
    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 1;
    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_mask = '0;
    logic [2:0]  num;
    logic [7:0]  sel;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    seg7_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
        .dp_mask(dp_mask), .num(num), .sel(sel), .seg(seg)
    );

    typedef struct {
        logic        en;
        logic        load;
        logic [31:0] data;
        logic [7:0]  dp;
        logic [2:0]  num;
        logic [7:0]  sel;
        logic [7:0]  seg;
    } vec_t;

    typedef struct {
        logic [2:0] num;
        logic [7:0] sel;
        logic [7:0] seg;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          mk = 0;          // edges with en=1 since scan restart
    logic [31:0] mdata = '0;

    // Slot-position model: digit = k/CLK_DIV mod 8, dark for the first BLANK_CYC counts of a slot.
    function automatic exp_t model(int k, logic [31:0] d, logic [7:0] dp);
        exp_t       e;
        int         dig;
        logic [3:0] n;
        logic [7:0] h;
        dig   = (k / CLK_DIV) % 8;
        e.num = dig[2:0];
        if ((k % CLK_DIV) < BLANK_CYC) begin
            e.sel = 8'hFF;
            e.seg = 8'hFF;
        end else begin
            e.sel = ~(8'h01 << dig);
            n     = d[4*dig +: 4];
            h     = HEX[n];
            e.seg = {~dp[dig], h[6:0]};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (dig > 0 && (d >> (4*dig)) == 32'd0) e.seg[6:0] = 7'h7F;
`endif
        end
        return e;
    endfunction

    function automatic void add(logic e, logic l, logic [31:0] d, logic [7:0] dp);
        vec_t v;
        exp_t x;
        if (l) mdata = d;
        if (!e) mk = 0;
        else mk++;
        x = model(mk, mdata, dp);
        v.en = e; v.load = l; v.data = d; v.dp = dp;
        v.num = x.num; v.sel = x.sel; v.seg = x.seg;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic drive(vec_t v);
        exp_t e;
        en = v.en; load = v.load; data_in = v.data; dp_mask = v.dp;
        sb.push_back('{num: v.num, sel: v.sel, seg: v.seg});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("num", {29'd0, num}, {29'd0, e.num});
        chk("sel", {24'd0, sel}, {24'd0, e.sel});
        chk("seg", {24'd0, seg}, {24'd0, e.seg});
        chk("sel_onehot", {31'd0, $countones(~sel) <= 1}, 32'd1);
    endtask

    task automatic step(logic e, logic l, logic [31:0] d, logic [7:0] dp);
        add(e, l, d, dp);
        drive(vecs[$]);
    endtask

    initial begin
        // basic scan: load while disabled, then 33 edges to see the wrap to digit 0
        add(1'b0, 1'b1, 32'h76543210, 8'h00);
        for (int i = 0; i < 33; i++) add(1'b1, 1'b0, 32'h0, 8'h00);
        // load honoured with en low; dp on digit 0 only
        add(1'b0, 1'b1, 32'hFEDCBA98, 8'h01);
        for (int i = 0; i < 32; i++) add(1'b1, 1'b0, 32'h0, 8'h01);
        // mid-SHOW load during digit 3 (k=13 is its first lit cycle)
        add(1'b0, 1'b1, 32'h00000000, 8'h00);
        for (int i = 0; i < 13; i++) add(1'b1, 1'b0, 32'h0, 8'h00);
        add(1'b1, 1'b1, 32'h11111111, 8'h00);
        for (int i = 0; i < 7; i++) add(1'b1, 1'b0, 32'h0, 8'h00);
        // k=21 is digit 5 lit; drop en, hold, then restart from digit 0
        add(1'b0, 1'b0, 32'h0, 8'h00);
        add(1'b0, 1'b0, 32'h0, 8'h00);
        for (int i = 0; i < 6; i++) add(1'b1, 1'b0, 32'h0, 8'h00);
        // leading zeros
        add(1'b0, 1'b1, 32'h00000120, 8'h00);
        for (int i = 0; i < 32; i++) add(1'b1, 1'b0, 32'h0, 8'h00);

        #1 rst_n = 1'b0;
        #1;
        chk("rst_sel_async", {24'd0, sel}, 32'h0000_00FF);
        chk("rst_seg_async", {24'd0, seg}, 32'h0000_00FF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_num", {29'd0, num}, 32'd0);
        chk("rst_sel", {24'd0, sel}, 32'h0000_00FF);
        chk("rst_seg", {24'd0, seg}, 32'h0000_00FF);

        mk = 0;
        mdata = '0;
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

        // async reset while digit 0 is lit
        step(1'b1, 1'b0, 32'h0, 8'h00);
        step(1'b1, 1'b0, 32'h0, 8'h00);
        chk("pre_rst_lit", {24'd0, sel}, 32'h0000_00FE);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sel", {24'd0, sel}, 32'h0000_00FF);
        chk("midrst_seg", {24'd0, seg}, 32'h0000_00FF);
        chk("midrst_num", {29'd0, num}, 32'd0);
        mk = 0;
        mdata = '0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
